// File: rtl/bcp_var_state_if.sv
// Controller/clause-array bundle for bcp_var_state.
// master = search controller + clause array side, slave = the store.
interface bcp_var_state_if #(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16
);
  logic                          dcd_valid_i;
  logic [$clog2(NUM_VARS)-1:0]   dcd_var_i;
  logic [1:0]                    dcd_value_i;
  logic [WIDTH_LVL-1:0]          dcd_lvl_i;
  logic                          bkt_valid_i;
  logic [WIDTH_LVL-1:0]          bkt_lvl_i;
  logic [NUM_VARS*3-1:0]         var_value_o;
  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_o;
  logic [NUM_VARS*3-1:0]         var_value_down_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          conflict_o;
  logic                          abort_o;
  logic [$clog2(NUM_VARS+1)-1:0] imp_cnt_o;

  modport master (
    output dcd_valid_i, dcd_var_i, dcd_value_i, dcd_lvl_i,
    output bkt_valid_i, bkt_lvl_i, var_value_down_i,
    input  var_value_o, var_lvl_o, busy_o, done_o,
    input  conflict_o, abort_o, imp_cnt_o
  );

  modport slave (
    input  dcd_valid_i, dcd_var_i, dcd_value_i, dcd_lvl_i,
    input  bkt_valid_i, bkt_lvl_i, var_value_down_i,
    output var_value_o, var_lvl_o, busy_o, done_o,
    output conflict_o, abort_o, imp_cnt_o
  );
endinterface

// File: rtl/bcp_var_state.sv
// Variable assignment/level store closing the BCP loop around
// the clause array: decisions, implication fixed point, backtrack.
module bcp_var_state #(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16,
  parameter int MAX_ITER  = 15
) (
  input logic           clk,
  input logic           rst,
  bcp_var_state_if.slave bus
);
  localparam int CW = $clog2(NUM_VARS + 1);
  localparam int IW = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {IDLE, PROP, DONE, BKT} state_e;

  state_e state_q, state_d;
  logic [NUM_VARS-1:0][2:0]           val_q, val_d;
  logic [NUM_VARS-1:0][WIDTH_LVL-1:0] lvl_q, lvl_d;
  logic [WIDTH_LVL-1:0] cur_lvl_q, cur_lvl_d;
  logic [WIDTH_LVL-1:0] tgt_lvl_q, tgt_lvl_d;
  logic [IW-1:0]        iter_q, iter_d;
  logic [CW-1:0]        imp_cnt_q, imp_cnt_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic conflict_q, conflict_d;
  logic abort_q, abort_d;

  logic [NUM_VARS-1:0][1:0] dn_v;
  logic [NUM_VARS-1:0]      cfl_v, new_v, unused_dn;
  logic [CW-1:0]            new_cnt;
  logic [IW-1:0]            iter_nx;

  // Implied-flag bits on the down path carry no information here.
  always_comb begin
    dn_v      = '0;
    cfl_v     = '0;
    new_v     = '0;
    unused_dn = '0;
    new_cnt   = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      dn_v[i]      = bus.var_value_down_i[3*i +: 2];
      unused_dn[i] = bus.var_value_down_i[3*i+2];
      cfl_v[i] = (dn_v[i] == 2'b11) ||
                 ((dn_v[i] != 2'b00) &&
                  (val_q[i][1:0] != 2'b00) &&
                  (dn_v[i] != val_q[i][1:0]));
      new_v[i] = (val_q[i][1:0] == 2'b00) &&
                 (dn_v[i] != 2'b00);
      new_cnt  = new_cnt + CW'(new_v[i]);
    end
  end

  assign iter_nx = iter_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    lvl_d      = lvl_q;
    cur_lvl_d  = cur_lvl_q;
    tgt_lvl_d  = tgt_lvl_q;
    iter_d     = iter_q;
    imp_cnt_d  = imp_cnt_q;
    conflict_d = conflict_q;
    abort_d    = abort_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dcd_valid_i) begin
          conflict_d = 1'b0;
          abort_d    = 1'b0;
          imp_cnt_d  = '0;
          iter_d     = '0;
          if (val_q[bus.dcd_var_i][1:0] != 2'b00) begin
            conflict_d = 1'b1;
            state_d    = DONE;
          end else begin
            val_d[bus.dcd_var_i] = {1'b0, bus.dcd_value_i};
            lvl_d[bus.dcd_var_i] = bus.dcd_lvl_i;
            cur_lvl_d = bus.dcd_lvl_i;
            state_d   = PROP;
          end
        end else if (bus.bkt_valid_i) begin
          conflict_d = 1'b0;
          abort_d    = 1'b0;
          imp_cnt_d  = '0;
          tgt_lvl_d  = bus.bkt_lvl_i;
          state_d    = BKT;
        end
      end
      PROP: begin
        if (|cfl_v) begin
          conflict_d = 1'b1;
          state_d    = DONE;
        end else if (!(|new_v)) begin
          state_d = DONE;
        end else begin
          for (int i = 0; i < NUM_VARS; i++) begin
            if (new_v[i]) begin
              val_d[i] = {1'b1, dn_v[i]};
              lvl_d[i] = cur_lvl_q;
            end
          end
          imp_cnt_d = imp_cnt_q + new_cnt;
          iter_d    = iter_nx;
          if (iter_nx == IW'(MAX_ITER)) begin
            abort_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      BKT: begin
        for (int i = 0; i < NUM_VARS; i++) begin
          if (lvl_q[i] > tgt_lvl_q) begin
            val_d[i] = '0;
            lvl_d[i] = '0;
          end
        end
        cur_lvl_d = tgt_lvl_q;
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      val_q      <= '0;
      lvl_q      <= '0;
      cur_lvl_q  <= '0;
      tgt_lvl_q  <= '0;
      iter_q     <= '0;
      imp_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      lvl_q      <= lvl_d;
      cur_lvl_q  <= cur_lvl_d;
      tgt_lvl_q  <= tgt_lvl_d;
      iter_q     <= iter_d;
      imp_cnt_q  <= imp_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.var_value_o = val_q;
  assign bus.var_lvl_o   = lvl_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.conflict_o  = conflict_q;
  assign bus.abort_o     = abort_q;
  assign bus.imp_cnt_o   = imp_cnt_q;
endmodule

// File: tb/tb_bcp_var_state.sv
// Directed bench for bcp_var_state with a small 2-literal
// clause array model on the down path.
module tb_bcp_var_state;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   mode_a = 0;
  int   mode_b = 3;

  always #5 clk = ~clk;

  bcp_var_state_if #(.NUM_VARS(8), .WIDTH_LVL(16)) bif_a ();
  bcp_var_state_if #(.NUM_VARS(8), .WIDTH_LVL(16)) bif_b ();

  bcp_var_state #(
    .NUM_VARS(8), .WIDTH_LVL(16), .MAX_ITER(15)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bif_a)
  );

  bcp_var_state #(
    .NUM_VARS(8), .WIDTH_LVL(16), .MAX_ITER(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bif_b)
  );

  // A false literal forces the other literal's satisfying value.
  function automatic logic [23:0] imp(
    input logic [23:0] d, input logic [23:0] vv,
    input int va, input int pa, input int vb, input int pb
  );
    logic [23:0] r;
    r = d;
    if (vv[3*va +: 2] == ((pa != 0) ? 2'b01 : 2'b10))
      r[3*vb +: 2] = r[3*vb +: 2] | ((pb != 0) ? 2'b10 : 2'b01);
    if (vv[3*vb +: 2] == ((pb != 0) ? 2'b01 : 2'b10))
      r[3*va +: 2] = r[3*va +: 2] | ((pa != 0) ? 2'b10 : 2'b01);
    return r;
  endfunction

  function automatic logic [23:0] clause_down(
    input logic [23:0] vv, input int mode
  );
    logic [23:0] d;
    d = vv & 24'o33333333;
    case (mode)
      1: begin
        d = imp(d, vv, 1, 0, 3, 1);
        d = imp(d, vv, 3, 0, 5, 1);
      end
      2: begin
        d = imp(d, vv, 1, 0, 3, 1);
        d = imp(d, vv, 1, 0, 3, 0);
      end
      3: begin
        d = imp(d, vv, 1, 0, 3, 1);
        d = imp(d, vv, 3, 0, 5, 1);
        d = imp(d, vv, 5, 0, 7, 1);
      end
      default: ;
    endcase
    return d;
  endfunction

  always_comb bif_a.var_value_down_i =
    clause_down(bif_a.var_value_o, mode_a);
  always_comb bif_b.var_value_down_i =
    clause_down(bif_b.var_value_o, mode_b);

  task automatic chk(
    input string tag, input logic [31:0] got, input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_a(input int start, output int lat);
    lat = start;
    while (!bif_a.done_o && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic dcd_a(
    input int v, input logic [1:0] val, input int lvl, output int lat
  );
    bif_a.dcd_valid_i = 1'b1;
    bif_a.dcd_var_i   = 3'(v);
    bif_a.dcd_value_i = val;
    bif_a.dcd_lvl_i   = 16'(lvl);
    step();
    bif_a.dcd_valid_i = 1'b0;
    wait_a(1, lat);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [2:0] va(input int i);
    return bif_a.var_value_o[3*i +: 3];
  endfunction

  function automatic logic [15:0] la(input int i);
    return bif_a.var_lvl_o[16*i +: 16];
  endfunction

  int lat;
  int dones;

  initial begin
    bif_a.dcd_valid_i = 1'b0;
    bif_a.dcd_var_i   = '0;
    bif_a.dcd_value_i = '0;
    bif_a.dcd_lvl_i   = '0;
    bif_a.bkt_valid_i = 1'b0;
    bif_a.bkt_lvl_i   = '0;
    bif_b.dcd_valid_i = 1'b0;
    bif_b.dcd_var_i   = '0;
    bif_b.dcd_value_i = '0;
    bif_b.dcd_lvl_i   = '0;
    bif_b.bkt_valid_i = 1'b0;
    bif_b.bkt_lvl_i   = '0;
    step();
    step();
    chk("rst_val", 32'(bif_a.var_value_o), 0);
    chk("rst_lvl_or", 32'(|bif_a.var_lvl_o), 0);
    chk("rst_flags",
        {bif_a.busy_o, bif_a.done_o, bif_a.conflict_o, bif_a.abort_o}, 0);
    chk("rst_imp", 32'(bif_a.imp_cnt_o), 0);
    rst = 1'b0;
    step();

    // single decision, echo array
    mode_a = 0;
    dcd_a(3, 2'b10, 1, lat);
    chk("dec_lat", lat, 2);
    chk("dec_val3", 32'(va(3)), 32'h2);
    chk("dec_lvl3", 32'(la(3)), 1);
    chk("dec_imp", 32'(bif_a.imp_cnt_o), 0);
    chk("dec_cfl", 32'(bif_a.conflict_o), 0);
    step();
    chk("dec_idle", {bif_a.busy_o, bif_a.done_o}, 0);

    // re-decide an assigned var
    dcd_a(3, 2'b01, 4, lat);
    chk("redec_lat", lat, 1);
    chk("redec_cfl", 32'(bif_a.conflict_o), 1);
    chk("redec_val3", 32'(va(3)), 32'h2);
    chk("redec_lvl3", 32'(la(3)), 1);
    step();

    // backtrack
    dcd_a(2, 2'b01, 2, lat);
    step();
    dcd_a(5, 2'b10, 3, lat);
    step();
    chk("pre_bkt_lvl5", 32'(la(5)), 3);
    bif_a.bkt_valid_i = 1'b1;
    bif_a.bkt_lvl_i   = 16'd1;
    step();
    bif_a.bkt_valid_i = 1'b0;
    wait_a(1, lat);
    chk("bkt_lat", lat, 2);
    chk("bkt_val3", 32'(va(3)), 32'h2);
    chk("bkt_lvl3", 32'(la(3)), 1);
    chk("bkt_val2", 32'(va(2)), 0);
    chk("bkt_lvl2", 32'(la(2)), 0);
    chk("bkt_val5", 32'(va(5)), 0);
    chk("bkt_lvl5", 32'(la(5)), 0);
    chk("bkt_cfl", 32'(bif_a.conflict_o), 0);
    step();

    // implication chain
    rst_pulse();
    mode_a = 1;
    dcd_a(1, 2'b10, 2, lat);
    chk("chain_lat", lat, 4);
    chk("chain_val1", 32'(va(1)), 32'h2);
    chk("chain_val3", 32'(va(3)), 32'h6);
    chk("chain_val5", 32'(va(5)), 32'h6);
    chk("chain_lvl3", 32'(la(3)), 2);
    chk("chain_lvl5", 32'(la(5)), 2);
    chk("chain_imp", 32'(bif_a.imp_cnt_o), 2);
    chk("chain_cfl", {bif_a.conflict_o, bif_a.abort_o}, 0);
    step();

    // conflict
    rst_pulse();
    mode_a = 2;
    dcd_a(1, 2'b10, 1, lat);
    chk("cfl_lat", lat, 2);
    chk("cfl_flag", 32'(bif_a.conflict_o), 1);
    chk("cfl_val3", 32'(va(3)), 0);
    chk("cfl_imp", 32'(bif_a.imp_cnt_o), 0);
    step();
    step();
    chk("cfl_hold", {bif_a.conflict_o, bif_a.done_o}, 32'h2);

    // reset mid-PROP
    rst_pulse();
    mode_a = 1;
    bif_a.dcd_valid_i = 1'b1;
    bif_a.dcd_var_i   = 3'd1;
    bif_a.dcd_value_i = 2'b10;
    bif_a.dcd_lvl_i   = 16'd2;
    step();
    bif_a.dcd_valid_i = 1'b0;
    chk("mid_busy", 32'(bif_a.busy_o), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_val", 32'(bif_a.var_value_o), 0);
    chk("mid_rst_lvl", 32'(|bif_a.var_lvl_o), 0);
    chk("mid_rst_flags",
        {bif_a.busy_o, bif_a.done_o, bif_a.conflict_o, bif_a.abort_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bif_a.done_o) dones++;
    end
    chk("mid_no_done", dones, 0);
    chk("mid_val_after", 32'(bif_a.var_value_o), 0);

    // request during PROP is ignored
    bif_a.dcd_valid_i = 1'b1;
    bif_a.dcd_var_i   = 3'd1;
    bif_a.dcd_value_i = 2'b10;
    bif_a.dcd_lvl_i   = 16'd2;
    step();
    bif_a.dcd_var_i   = 3'd0;
    bif_a.dcd_lvl_i   = 16'd5;
    step();
    bif_a.dcd_valid_i = 1'b0;
    wait_a(2, lat);
    chk("ign_lat", lat, 4);
    chk("ign_val0", 32'(va(0)), 0);
    chk("ign_lvl0", 32'(la(0)), 0);
    chk("ign_val5", 32'(va(5)), 32'h6);
    chk("ign_imp", 32'(bif_a.imp_cnt_o), 2);
    step();

    // abort with MAX_ITER=2 on a 3-step chain
    bif_b.dcd_valid_i = 1'b1;
    bif_b.dcd_var_i   = 3'd1;
    bif_b.dcd_value_i = 2'b10;
    bif_b.dcd_lvl_i   = 16'd1;
    step();
    bif_b.dcd_valid_i = 1'b0;
    lat = 1;
    while (!bif_b.done_o && lat < 40) begin
      step();
      lat++;
    end
    chk("abt_lat", lat, 3);
    chk("abt_flag", {bif_b.abort_o, bif_b.conflict_o}, 32'h2);
    chk("abt_imp", 32'(bif_b.imp_cnt_o), 2);
    chk("abt_val5", 32'(bif_b.var_value_o[15 +: 3]), 32'h6);
    chk("abt_val7", 32'(bif_b.var_value_o[21 +: 3]), 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
